i2s_playback_ctrl: RTL and testbench

Sequencer for the audio playback datapath: it walks a sample ROM address range and serializes each sample onto the I2S data line, slaved to the LRCLK/SCLK driven by the codec on the Arduino header. It runs in the 50 MHz fabric clock domain, synchronizes the codec clocks internally, and gives software-facing play/pause/stop/loop control in place of free-running address counters clocked directly by codec pins.

---
 rtl/i2s_pkg.sv | 25 ++
 rtl/i2s_edge_sync.sv | 40 ++++
 rtl/i2s_playback_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2s_playback_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared types and constants for the I2S playback sequencer:
//                state encoding, default sample/slot widths, I2S data delay.
//  Revision    : 1.0  initial release
// ============================================================================
package i2s_pkg;

    // Playback sequencer states; encodings are visible on state_o
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        PLAY  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam int c_SAMPLE_W_DEF = 16;
    localparam int c_SLOT_W_DEF   = 32;

    // First data bit follows the LRCLK transition by one SCLK period
    localparam int c_I2S_DELAY    = 1;

endpackage
`default_nettype wire

// File: rtl/i2s_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_edge_sync
//  Description : Multi-flop synchronizer for an asynchronous codec clock pin,
//                followed by one history flop producing single-cycle
//                rise/fall pulses in the fabric clock domain.
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain plus previous-value flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/i2s_playback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_playback_ctrl
//  Description : Walks a sample ROM address range and serializes each word
//                onto the I2S data line, slaved to codec LRCLK/SCLK which are
//                synchronized into the fabric clock domain. Provides
//                play/pause/stop/loop control.
//  Options     : STEREO_EN - rom_q carries {left, right} (2*SAMPLE_W bits);
//                otherwise one SAMPLE_W word is sent on both channels.
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_playback_ctrl
    import i2s_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int SAMPLE_W    = c_SAMPLE_W_DEF,
    parameter int SLOT_W      = c_SLOT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lrclk_in,
    input  logic                  sclk_in,
    input  logic                  play,
    input  logic                  pause,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W-1:0]     end_addr,
    output logic [ADDR_W-1:0]     rom_addr,
`ifdef STEREO_EN
    input  logic [2*SAMPLE_W-1:0] rom_q,
`else
    input  logic [SAMPLE_W-1:0]   rom_q,
`endif
    output logic                  sdin,
    output logic [1:0]            state_o,
    output logic                  frame_tick,
    output logic                  done
);

    localparam int c_CNT_W = $clog2(SLOT_W + 1);

    state_t              r_state;
    state_t              w_next;
    logic                w_load;
    logic                w_finish;
    logic                w_latch;

    logic                w_lr_rise;
    logic                w_lr_fall;
    logic                w_sclk_rise;
    logic                w_sclk_fall;

    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W-1:0]   r_end;
    logic                r_tick;
    logic                r_done;
    logic                r_last;
    logic                r_pause_req;

    logic [SAMPLE_W-1:0] r_sh_l;
    logic [SAMPLE_W-1:0] r_sh_r;
    logic [c_CNT_W-1:0]  r_bitcnt;
    logic                r_chan;
    logic                r_sdin;

    logic [SAMPLE_W-1:0] w_left;
    logic [SAMPLE_W-1:0] w_right;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                w_in_win;

`ifdef STEREO_EN
    assign w_left  = rom_q[2*SAMPLE_W-1:SAMPLE_W];
    assign w_right = rom_q[SAMPLE_W-1:0];
`else
    assign w_left  = rom_q;
    assign w_right = rom_q;
`endif

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lr_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (lrclk_in),
        .o_rise  (w_lr_rise),
        .o_fall  (w_lr_fall)
    );

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (sclk_in),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // SCLK rising edges carry no action here; the codec samples on them
    logic w_unused;
    assign w_unused = w_sclk_rise;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and frame-level control strobes; stop overrides all
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_finish = 1'b0;
        w_latch  = 1'b0;
        if (stop) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (play) begin
                        w_next  = ARM;
                        w_latch = 1'b1;
                    end
                end
                ARM: begin
                    if (w_lr_fall) begin
                        w_next = PLAY;
                        w_load = 1'b1;
                    end
                end
                PLAY: begin
                    if (w_lr_fall) begin
                        if (r_last) begin
                            w_next   = IDLE;
                            w_finish = 1'b1;
                        end else if (r_pause_req || pause) begin
                            w_next = PAUSE;
                        end else begin
                            w_load = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (play) begin
                        w_next = ARM;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Address counter, range latch, pending pause / last-word flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_start     <= '0;
            r_end       <= '0;
            r_tick      <= 1'b0;
            r_done      <= 1'b0;
            r_last      <= 1'b0;
            r_pause_req <= 1'b0;
        end else if (stop) begin
            r_addr      <= start_addr;
            r_tick      <= 1'b0;
            r_done      <= 1'b0;
            r_last      <= 1'b0;
            r_pause_req <= 1'b0;
        end else begin
            r_tick      <= w_load;
            r_done      <= w_finish;
            r_pause_req <= (r_state == PLAY) && (w_next == PLAY) &&
                           (r_pause_req || pause);
            if (w_latch) begin
                r_start <= start_addr;
                r_end   <= end_addr;
            end
            // Advance the cycle after frame_tick so rom_addr trails it by one
            if (r_state == IDLE) begin
                r_addr <= start_addr;
            end else if (r_tick) begin
                if (r_addr == r_end) begin
                    if (loop_en) begin
                        r_addr <= r_start;
                    end
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
            if (w_next != PLAY) begin
                r_last <= 1'b0;
            end else if (r_tick && (r_addr == r_end) && !loop_en) begin
                r_last <= 1'b1;
            end
        end
    end

    assign w_cnt_inc = r_bitcnt + 1'b1;
    assign w_in_win  = (w_cnt_inc >= c_CNT_W'(c_I2S_DELAY)) &&
                       (w_cnt_inc <  c_CNT_W'(c_I2S_DELAY + SAMPLE_W));

    // Per-channel shift registers and bit counter driving sdin
    always_ff @(posedge clk) begin
        if (reset || stop) begin
            r_sh_l   <= '0;
            r_sh_r   <= '0;
            r_bitcnt <= '0;
            r_chan   <= 1'b0;
            r_sdin   <= 1'b0;
        end else if (w_lr_fall || w_lr_rise) begin
            r_bitcnt <= '0;
            r_chan   <= w_lr_rise;
            r_sdin   <= 1'b0;
            if (w_load) begin
                r_sh_l <= w_left;
                r_sh_r <= w_right;
            end else if (w_lr_fall) begin
                r_sh_l <= '0;
                r_sh_r <= '0;
            end
        end else if (w_sclk_fall) begin
            if (r_bitcnt != c_CNT_W'(SLOT_W)) begin
                r_bitcnt <= w_cnt_inc;
            end
            if ((r_state == PLAY) && w_in_win) begin
                if (r_chan) begin
                    r_sdin <= r_sh_r[SAMPLE_W-1];
                    r_sh_r <= r_sh_r << 1;
                end else begin
                    r_sdin <= r_sh_l[SAMPLE_W-1];
                    r_sh_l <= r_sh_l << 1;
                end
            end else begin
                r_sdin <= 1'b0;
            end
        end
    end

    assign rom_addr   = r_addr;
    assign sdin       = r_sdin;
    assign state_o    = r_state;
    assign frame_tick = r_tick;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_i2s_playback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_playback_ctrl
//  Description : Directed self-checking bench for i2s_playback_ctrl. Models
//                the codec clocks and an I2S receiver, plus a 2-cycle ROM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2s_playback_ctrl;

`ifdef STEREO_EN
    localparam int c_RQ_W = 32;
`else
    localparam int c_RQ_W = 16;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              lrclk_in;
    logic              sclk_in;
    logic              play, pause, stop, loop_en;
    logic [15:0]       start_addr, end_addr, rom_addr;
    logic [c_RQ_W-1:0] rom_q, rom_d1;
    logic              sdin, frame_tick, done;
    logic [1:0]        state_o;

    int n_checks = 0;
    int n_errs   = 0;
    int tick_cnt = 0;
    int done_cnt = 0;
    int bad_idle = 0;
    int pad_bad  = 0;
    int pos      = 63;
    int hp;
    int t0, d0;

    logic [15:0]       rom_xor;
    logic              force_en;
    logic [c_RQ_W-1:0] force_val;
    logic [15:0]       acc, cap_l;
    logic              have_l;
    logic [31:0]       frames_q[$];

    i2s_playback_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .lrclk_in   (lrclk_in),
        .sclk_in    (sclk_in),
        .play       (play),
        .pause      (pause),
        .stop       (stop),
        .loop_en    (loop_en),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .sdin       (sdin),
        .state_o    (state_o),
        .frame_tick (frame_tick),
        .done       (done)
    );

    always #10 clk = ~clk;

    // Codec: SCLK half-period 120 ns, LRCLK toggles on SCLK falls, 32-bit slots
    initial begin
        sclk_in  = 1'b1;
        lrclk_in = 1'b1;
        #7;
        forever begin
            sclk_in  = 1'b0;
            pos      = (pos + 1) % 64;
            lrclk_in = (pos >= 32);
            #120;
            sclk_in  = 1'b1;
            #120;
        end
    end

    // I2S receiver: bits 1..16 of each half-frame form the word, rest must be 0
    always @(posedge sclk_in) begin
        hp = pos % 32;
        if (hp >= 1 && hp <= 16) begin
            acc = {acc[14:0], sdin};
        end else if (sdin !== 1'b0 && !reset) begin
            pad_bad++;
        end
        if (hp == 16) begin
            if (pos < 32) begin
                cap_l  = acc;
                have_l = 1'b1;
            end else if (have_l) begin
                frames_q.push_back({cap_l, acc});
            end
        end
    end

    // ROM with two cycles of read latency
    function automatic logic [c_RQ_W-1:0] rom_fn(input logic [15:0] a);
        logic [15:0] w;
        w = {a[7:0], a[7:0]} ^ rom_xor;
        if (force_en) return force_val;
`ifdef STEREO_EN
        return {w, w};
`else
        return w;
`endif
    endfunction

    always @(posedge clk) begin
        rom_d1 <= rom_fn(rom_addr);
        rom_q  <= rom_d1;
    end

    always @(negedge clk) begin
        if (frame_tick === 1'b1) tick_cnt++;
        if (done === 1'b1) done_cnt++;
        if (state_o !== 2'd2 && sdin === 1'b1) bad_idle++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_frame(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] v;
        v = (idx < frames_q.size()) ? frames_q[idx] : 32'hDEAD_BEEF;
        check_eq(tag, v, exp);
    endtask

    task automatic clear_cap();
        frames_q.delete();
        have_l = 1'b0;
    endtask

    task automatic pulse_play();
        @(negedge clk) play = 1'b1;
        @(negedge clk) play = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    task automatic wait_falls(input int n);
        repeat (n) @(negedge lrclk_in);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
        start_addr = 16'h0010; end_addr = 16'h0012;
        rom_xor = 16'h0000; force_en = 1'b0; force_val = '0;
        acc = '0; cap_l = '0; have_l = 1'b0;

        // Reset values
        repeat (5) @(negedge clk);
        check_eq("rst_state", {30'd0, state_o}, 32'd0);
        check_eq("rst_addr", {16'd0, rom_addr}, 32'd0);
        check_eq("rst_sdin", {31'd0, sdin}, 32'd0);
        check_eq("rst_tick", {31'd0, frame_tick}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_track", {16'd0, rom_addr}, 32'h10);

        // Play 0x10..0x12 without loop
        @(posedge lrclk_in);
        clear_cap(); t0 = tick_cnt; d0 = done_cnt;
        pulse_play();
        check_eq("t1_arm", {30'd0, state_o}, 32'd1);
        wait_falls(5);
        check_eq("t1_ticks", tick_cnt - t0, 32'd3);
        check_eq("t1_done", done_cnt - d0, 32'd1);
        check_eq("t1_state", {30'd0, state_o}, 32'd0);
        check_eq("t1_addr", {16'd0, rom_addr}, 32'h10);
        check_eq("t1_nfr", frames_q.size(), 32'd4);
        check_frame("t1_f0", 0, 32'h1010_1010);
        check_frame("t1_f1", 1, 32'h1111_1111);
        check_frame("t1_f2", 2, 32'h1212_1212);
        check_frame("t1_f3", 3, 32'h0000_0000);

        // Loop 0..1; start_addr changed after play must not affect the range
        start_addr = 16'h0000; end_addr = 16'h0001; loop_en = 1'b1; rom_xor = 16'hFFFF;
        @(posedge lrclk_in);
        clear_cap(); t0 = tick_cnt; d0 = done_cnt;
        pulse_play();
        start_addr = 16'h0033;
        wait_falls(7);
        check_eq("t2_ticks", tick_cnt - t0, 32'd7);
        check_eq("t2_done", done_cnt - d0, 32'd0);
        check_eq("t2_nfr", frames_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_frame("t2_fr", i, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'hFEFE_FEFE);
        end

        // stop + pause in the same cycle mid data bit
        @(negedge lrclk_in);
        repeat (5) @(posedge sclk_in);
        @(negedge clk) begin stop = 1'b1; pause = 1'b1; end
        @(negedge clk) begin stop = 1'b0; pause = 1'b0; end
        check_eq("t4_state", {30'd0, state_o}, 32'd0);
        check_eq("t4_sdin", {31'd0, sdin}, 32'd0);
        check_eq("t4_addr", {16'd0, rom_addr}, 32'h33);
        d0 = done_cnt;
        wait_falls(2);
        check_eq("t4_nodone", done_cnt - d0, 32'd0);

        // Pause at address 5, resume with 6
        start_addr = 16'h0003; end_addr = 16'h0020; loop_en = 1'b0; rom_xor = 16'h0000;
        @(posedge lrclk_in);
        clear_cap(); t0 = tick_cnt;
        pulse_play();
        wait_falls(3);
        @(posedge lrclk_in);
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        check_eq("t3_still_play", {30'd0, state_o}, 32'd2);
        wait_falls(1);
        check_eq("t3_paused", {30'd0, state_o}, 32'd3);
        check_eq("t3_addr_a", {16'd0, rom_addr}, 32'h6);
        wait_falls(2);
        check_eq("t3_addr_b", {16'd0, rom_addr}, 32'h6);
        check_eq("t3_ticks_a", tick_cnt - t0, 32'd3);
        @(posedge lrclk_in);
        pulse_play();
        check_eq("t3_rearm", {30'd0, state_o}, 32'd1);
        wait_falls(1);
        check_eq("t3_resume", {30'd0, state_o}, 32'd2);
        check_eq("t3_ticks_b", tick_cnt - t0, 32'd4);
        wait_falls(1);
        check_eq("t3_nfr", frames_q.size(), 32'd7);
        check_frame("t3_f0", 0, 32'h0303_0303);
        check_frame("t3_f1", 1, 32'h0404_0404);
        check_frame("t3_f2", 2, 32'h0505_0505);
        check_frame("t3_f3", 3, 32'h0000_0000);
        check_frame("t3_f5", 5, 32'h0000_0000);
        check_frame("t3_f6", 6, 32'h0606_0606);

        // Reset in the middle of a data bit
        repeat (6) @(posedge sclk_in);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check_eq("t5_state", {30'd0, state_o}, 32'd0);
        check_eq("t5_addr", {16'd0, rom_addr}, 32'd0);
        check_eq("t5_sdin", {31'd0, sdin}, 32'd0);
        check_eq("t5_tick", {31'd0, frame_tick}, 32'd0);
        check_eq("t5_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge lrclk_in);
        repeat (12) @(negedge clk);
        t0 = tick_cnt;
        pulse_play();
        @(posedge lrclk_in);
        clear_cap();
        check_eq("t5_wait_arm", {30'd0, state_o}, 32'd1);
        check_eq("t5_no_tick", tick_cnt - t0, 32'd0);
        wait_falls(1);
        check_eq("t5_play", {30'd0, state_o}, 32'd2);
        check_eq("t5_tick", tick_cnt - t0, 32'd1);
        wait_falls(1);
        check_eq("t5_nfr", frames_q.size(), 32'd1);
        check_frame("t5_f0", 0, 32'h0303_0303);
        pulse_stop();

        // start > end plays through the address wrap
        start_addr = 16'hFFFF; end_addr = 16'h0000; rom_xor = 16'h00F0;
        @(posedge lrclk_in);
        clear_cap(); t0 = tick_cnt; d0 = done_cnt;
        pulse_play();
        wait_falls(4);
        check_eq("t6_ticks", tick_cnt - t0, 32'd2);
        check_eq("t6_done", done_cnt - d0, 32'd1);
        check_eq("t6_nfr", frames_q.size(), 32'd3);
        check_frame("t6_f0", 0, 32'hFF0F_FF0F);
        check_frame("t6_f1", 1, 32'h00F0_00F0);

        // Channel mapping, single-word range looping
        start_addr = 16'h0040; end_addr = 16'h0040; loop_en = 1'b1; force_en = 1'b1;
`ifdef STEREO_EN
        force_val = 32'hABCD_1234;
`else
        force_val = 16'hABCD;
`endif
        @(posedge lrclk_in);
        clear_cap();
        pulse_play();
        wait_falls(3);
        check_eq("t7_nfr", frames_q.size(), 32'd2);
        check_eq("t7_addr", {16'd0, rom_addr}, 32'h40);
`ifdef STEREO_EN
        check_frame("t7_f0", 0, 32'hABCD_1234);
        check_frame("t7_f1", 1, 32'hABCD_1234);
`else
        check_frame("t7_f0", 0, 32'hABCD_ABCD);
        check_frame("t7_f1", 1, 32'hABCD_ABCD);
`endif
        pulse_stop();

        check_eq("pad_bits_zero", pad_bad, 32'd0);
        check_eq("sdin_zero_not_play", bad_idle, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
